// File: rtl/vga_pattern_gen.sv
// Video timing and test-pattern source feeding the OSD overlay; every output is one enabled clock behind the counter.
// No backpressure: clk_pixel_ena low freezes all state and holds the outputs static.
module vga_pattern_gen #(
  parameter int          c_bits_x      = 10,
  parameter int          c_bits_y      = 10,
  parameter int          c_h_visible   = 640,
  parameter int          c_h_fporch    = 16,
  parameter int          c_h_sync      = 96,
  parameter int          c_h_bporch    = 48,
  parameter int          c_v_visible   = 480,
  parameter int          c_v_fporch    = 10,
  parameter int          c_v_sync      = 2,
  parameter int          c_v_bporch    = 33,
  parameter bit          c_hsync_pol   = 1'b0,
  parameter bit          c_vsync_pol   = 1'b0,
  parameter int          c_bar_bits    = 6,
  parameter logic [23:0] c_solid_color = 24'h503020
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                clk_pixel_ena,
  input  logic [1:0]          i_mode,
  output logic [7:0]          o_r,
  output logic [7:0]          o_g,
  output logic [7:0]          o_b,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_blank,
  output logic [c_bits_x-1:0] o_x,
  output logic [c_bits_y-1:0] o_y,
  output logic                o_frame_start
);

  localparam int H_TOT = c_h_visible + c_h_fporch + c_h_sync + c_h_bporch;
  localparam int V_TOT = c_v_visible + c_v_fporch + c_v_sync + c_v_bporch;

  localparam logic [c_bits_x-1:0] X_ONE      = c_bits_x'(1);
  localparam logic [c_bits_x-1:0] X_LAST     = c_bits_x'(H_TOT - 1);
  localparam logic [c_bits_x-1:0] X_VIS      = c_bits_x'(c_h_visible);
  localparam logic [c_bits_x-1:0] X_VIS_LAST = c_bits_x'(c_h_visible - 1);
  localparam logic [c_bits_x-1:0] HS_FIRST   = c_bits_x'(c_h_visible + c_h_fporch);
  localparam logic [c_bits_x-1:0] HS_LAST    = c_bits_x'(c_h_visible + c_h_fporch + c_h_sync - 1);

  localparam logic [c_bits_y-1:0] Y_ONE      = c_bits_y'(1);
  localparam logic [c_bits_y-1:0] Y_LAST     = c_bits_y'(V_TOT - 1);
  localparam logic [c_bits_y-1:0] Y_VIS      = c_bits_y'(c_v_visible);
  localparam logic [c_bits_y-1:0] Y_VIS_LAST = c_bits_y'(c_v_visible - 1);
  localparam logic [c_bits_y-1:0] VS_FIRST   = c_bits_y'(c_v_visible + c_v_fporch);
  localparam logic [c_bits_y-1:0] VS_LAST    = c_bits_y'(c_v_visible + c_v_fporch + c_v_sync - 1);

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRID  = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  logic [c_bits_x-1:0] x_cnt;
  logic [c_bits_y-1:0] y_cnt;
  logic [1:0]          mode_q;
  logic [7:0]          frame_cnt;

  logic        at_origin;
  logic        x_wrap;
  logic        y_wrap;
  logic [1:0]  mode_cur;
  logic        blank_cur;
  logic        hs_act;
  logic        vs_act;
  logic [2:0]  bar_idx;
  logic        grid_on;
  logic [23:0] pattern;
  logic [23:0] rgb_cur;

  always_comb begin
    at_origin = (x_cnt == '0) && (y_cnt == '0);
    x_wrap    = (x_cnt == X_LAST);
    y_wrap    = (y_cnt == Y_LAST);
    // The origin pixel already uses the freshly sampled mode.
    mode_cur  = at_origin ? i_mode : mode_q;

    blank_cur = (x_cnt >= X_VIS) || (y_cnt >= Y_VIS);
    hs_act    = (x_cnt >= HS_FIRST) && (x_cnt <= HS_LAST);
    vs_act    = (y_cnt >= VS_FIRST) && (y_cnt <= VS_LAST);

    bar_idx   = x_cnt[c_bar_bits+2:c_bar_bits];
    grid_on   = (x_cnt[3:0] == 4'd0) || (y_cnt[3:0] == 4'd0) ||
                (x_cnt == X_VIS_LAST) || (y_cnt == Y_VIS_LAST);

    pattern = 24'h000000;
    case (mode_cur)
      MODE_BARS:  pattern = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
      MODE_GRID:  pattern = grid_on ? 24'hFFFFFF : 24'h000000;
      MODE_GRAD:  pattern = {x_cnt[7:0], y_cnt[7:0], frame_cnt};
      MODE_SOLID: pattern = c_solid_color;
      default:    pattern = 24'h000000;
    endcase

    rgb_cur = blank_cur ? 24'h000000 : pattern;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      x_cnt         <= '0;
      y_cnt         <= '0;
      mode_q        <= MODE_BARS;
      frame_cnt     <= 8'd0;
      o_r           <= 8'd0;
      o_g           <= 8'd0;
      o_b           <= 8'd0;
      o_blank       <= 1'b1;
      o_hsync       <= ~c_hsync_pol;
      o_vsync       <= ~c_vsync_pol;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
    end else if (clk_pixel_ena) begin
      if (x_wrap) begin
        x_cnt <= '0;
        y_cnt <= y_wrap ? '0 : y_cnt + Y_ONE;
      end else begin
        x_cnt <= x_cnt + X_ONE;
      end

      if (at_origin) mode_q <= i_mode;
      if (x_wrap && y_wrap) frame_cnt <= frame_cnt + 8'd1;

      o_r           <= rgb_cur[23:16];
      o_g           <= rgb_cur[15:8];
      o_b           <= rgb_cur[7:0];
      o_blank       <= blank_cur;
      o_hsync       <= hs_act ? c_hsync_pol : ~c_hsync_pol;
      o_vsync       <= vs_act ? c_vsync_pol : ~c_vsync_pol;
      o_x           <= x_cnt;
      o_y           <= y_cnt;
      o_frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken 16x9 raster (12x6 visible, 1-pixel bars).
// Stimulus queues hand-computed pixels; the monitor pops them as the DUT emits matching output.
module tb_vga_pattern_gen;

  localparam int HT = 16;
  localparam int VT = 9;
  localparam int FRAME = HT * VT;

  localparam logic [1:0] K_PIX  = 2'd0;
  localparam logic [1:0] K_RST  = 2'd1;
  localparam logic [1:0] K_HOLD = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        strict;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic       clk_pixel;
  logic       reset;
  logic       clk_pixel_ena;
  logic [1:0] i_mode;
  logic [7:0] o_r, o_g, o_b;
  logic       o_hsync, o_vsync, o_blank, o_frame_start;
  logic [9:0] o_x, o_y;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  vga_pattern_gen #(
    .c_bits_x(10), .c_bits_y(10),
    .c_h_visible(12), .c_h_fporch(1), .c_h_sync(2), .c_h_bporch(1),
    .c_v_visible(6), .c_v_fporch(1), .c_v_sync(1), .c_v_bporch(1),
    .c_hsync_pol(1'b0), .c_vsync_pol(1'b0),
    .c_bar_bits(0), .c_solid_color(24'h503020)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .clk_pixel_ena(clk_pixel_ena), .i_mode(i_mode),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_blank(o_blank), .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic push_x(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic pix(input string nm, input int x, input int y, input logic [23:0] rgb,
                     input logic blank, input logic hs, input logic vs, input logic fs);
    exp_t e;
    e.kind = K_PIX; e.strict = 1'b0; e.x = 10'(x); e.y = 10'(y);
    e.rgb = rgb; e.blank = blank; e.hs = hs; e.vs = vs; e.fs = fs;
    push_x(nm, e);
  endtask

  // Expected output for linear pixel p after reset with solid mode selected.
  function automatic exp_t solid_pix(input int p, input logic [1:0] kind);
    exp_t e;
    int x, y;
    logic vis;
    x = p % HT;
    y = p / HT;
    vis = (x < 12) && (y < 6);
    e.kind = kind; e.strict = 1'b1; e.x = 10'(x); e.y = 10'(y);
    e.rgb = vis ? 24'h503020 : 24'h000000;
    e.blank = !vis;
    e.hs = !(x == 13 || x == 14);
    e.vs = !(y == 7);
    e.fs = (p == 0);
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk_pixel);
  endtask

  // Monitor
  initial begin
    exp_t  e, got;
    string nm;
    logic  r_s, e_s, elig;
    forever begin
      @(posedge clk_pixel);
      r_s = reset;
      e_s = clk_pixel_ena;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        case (e.kind)
          K_RST:   elig = r_s;
          K_HOLD:  elig = !r_s && !e_s;
          default: elig = !r_s && e_s && (e.strict || (o_x == e.x && o_y == e.y));
        endcase
        if (elig) begin
          void'(exp_q.pop_front());
          nm = name_q.pop_front();
          got = e;
          got.x = o_x; got.y = o_y; got.rgb = {o_r, o_g, o_b};
          got.blank = o_blank; got.hs = o_hsync; got.vs = o_vsync; got.fs = o_frame_start;
          n_total++;
          if (got == e) n_pass++;
          else $display("FAIL %s: got x=%0d y=%0d rgb=%06h blank=%0b hsync=%0b vsync=%0b fs=%0b, expected x=%0d y=%0d rgb=%06h blank=%0b hsync=%0b vsync=%0b fs=%0b",
                        nm, got.x, got.y, got.rgb, got.blank, got.hs, got.vs, got.fs,
                        e.x, e.y, e.rgb, e.blank, e.hs, e.vs, e.fs);
        end
      end
    end
  end

  // Stimulus
  initial begin
    exp_t er;
    int   p, last;
    reset = 1'b1;
    clk_pixel_ena = 1'b1;
    i_mode = 2'd2;
    er = '0;
    er.kind = K_RST; er.blank = 1'b1; er.hs = 1'b1; er.vs = 1'b1;
    push_x("rst_init", er);
    step(2);

    n_total++;
    if (o_blank === 1'b1 && o_x === 10'd0 && o_y === 10'd0 && o_frame_start === 1'b0) n_pass++;
    else $display("FAIL rst_init_pos: blank=%0b x=%0d y=%0d fs=%0b", o_blank, o_x, o_y, o_frame_start);
    n_total++;
    if (o_hsync === 1'b1 && o_vsync === 1'b1 && {o_r, o_g, o_b} === 24'h000000) n_pass++;
    else $display("FAIL rst_init_sync: hsync=%0b vsync=%0b rgb=%06h", o_hsync, o_vsync, {o_r, o_g, o_b});

    // Frames 0..2: gradient, blue carries the frame counter
    pix("f0_origin", 0, 0, 24'h000000, 0, 1, 1, 1);
    pix("f0_grad",   5, 3, 24'h050300, 0, 1, 1, 0);
    pix("f0_blank", 12, 3, 24'h000000, 1, 1, 1, 0);
    pix("f0_hsync", 13, 3, 24'h000000, 1, 0, 1, 0);
    reset = 1'b0;
    step(FRAME);
    pix("f1_grad",   5, 3, 24'h050301, 0, 1, 1, 0);
    step(FRAME);
    pix("f2_grad",   5, 3, 24'h050302, 0, 1, 1, 0);
    pix("f2_grad_edge", 11, 5, 24'h0B0502, 0, 1, 1, 0);
    step(FRAME);

    // Frame 3: colour bars and sync timing
    i_mode = 2'd0;
    pix("bar_origin", 0, 0, 24'h000000, 0, 1, 1, 1);
    pix("bar1",       1, 0, 24'h0000FF, 0, 1, 1, 0);
    pix("bar2",       2, 0, 24'h00FF00, 0, 1, 1, 0);
    pix("bar4",       4, 0, 24'hFF0000, 0, 1, 1, 0);
    pix("bar7",       7, 0, 24'hFFFFFF, 0, 1, 1, 0);
    pix("bar_rep1",   9, 0, 24'h0000FF, 0, 1, 1, 0);
    pix("bar_rep3",  11, 0, 24'h00FFFF, 0, 1, 1, 0);
    pix("hblank",    12, 0, 24'h000000, 1, 1, 1, 0);
    pix("hs_first",  13, 0, 24'h000000, 1, 0, 1, 0);
    pix("hs_last",   14, 0, 24'h000000, 1, 0, 1, 0);
    pix("hs_after",  15, 0, 24'h000000, 1, 1, 1, 0);
    pix("vs_line",    3, 7, 24'h000000, 1, 1, 0, 0);
    pix("vs_hs",     13, 7, 24'h000000, 1, 0, 0, 0);
    pix("vs_after",   0, 8, 24'h000000, 1, 1, 1, 0);
    step(FRAME);

    // Frame 4: grid
    i_mode = 2'd1;
    pix("grid_origin", 0, 0, 24'hFFFFFF, 0, 1, 1, 1);
    pix("grid_top",    1, 0, 24'hFFFFFF, 0, 1, 1, 0);
    pix("grid_blank", 12, 0, 24'h000000, 1, 1, 1, 0);
    pix("grid_left",   0, 2, 24'hFFFFFF, 0, 1, 1, 0);
    pix("grid_off",    1, 2, 24'h000000, 0, 1, 1, 0);
    pix("grid_right", 11, 3, 24'hFFFFFF, 0, 1, 1, 0);
    pix("grid_off2",   3, 4, 24'h000000, 0, 1, 1, 0);
    pix("grid_bottom", 3, 5, 24'hFFFFFF, 0, 1, 1, 0);
    step(FRAME);

    // Frame 5: mode change mid-frame must wait for the next origin
    i_mode = 2'd0;
    pix("sw_before", 1, 2, 24'h0000FF, 0, 1, 1, 0);
    step(3 * HT);
    i_mode = 2'd3;
    pix("sw_held",   1, 4, 24'h0000FF, 0, 1, 1, 0);
    pix("sw_held7",  7, 5, 24'hFFFFFF, 0, 1, 1, 0);
    step(FRAME - 3 * HT);
    pix("sw_origin", 0, 0, 24'h503020, 0, 1, 1, 1);
    pix("solid",     5, 3, 24'h503020, 0, 1, 1, 0);
    pix("solid_blank", 12, 0, 24'h000000, 1, 1, 1, 0);
    step(FRAME);

    // Frames 7..256: frame counter wraps 255 -> 0
    i_mode = 2'd2;
    step(FRAME * 248);
    pix("fc_255", 5, 3, 24'h0503FF, 0, 1, 1, 0);
    step(FRAME);
    pix("fc_wrap_origin", 0, 0, 24'h000000, 0, 1, 1, 1);
    pix("fc_wrap", 5, 3, 24'h050300, 0, 1, 1, 0);
    step(FRAME);

    // Reset mid-frame at pixel (3,4), then toggle the enable
    step(4 * HT + 3);
    reset = 1'b1;
    er = '0;
    er.kind = K_RST; er.blank = 1'b1; er.hs = 1'b1; er.vs = 1'b1;
    push_x("rst_mid", er);
    step(1);
    n_total++;
    if (o_blank === 1'b1 && o_hsync === 1'b1 && o_vsync === 1'b1 && {o_r, o_g, o_b} === 24'h000000 &&
        o_x === 10'd0 && o_y === 10'd0 && o_frame_start === 1'b0) n_pass++;
    else $display("FAIL rst_mid_direct: blank=%0b hsync=%0b vsync=%0b rgb=%06h x=%0d y=%0d fs=%0b",
                  o_blank, o_hsync, o_vsync, {o_r, o_g, o_b}, o_x, o_y, o_frame_start);
    reset = 1'b0;
    i_mode = 2'd3;
    p = 0;
    last = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        clk_pixel_ena = 1'b1;
        push_x($sformatf("tog_pix%0d", p), solid_pix(p, K_PIX));
        last = p;
        p++;
      end else begin
        clk_pixel_ena = 1'b0;
        push_x($sformatf("tog_hold%0d", last), solid_pix(last, K_HOLD));
      end
      step(1);
    end
    clk_pixel_ena = 1'b1;
    step(3);

    while (exp_q.size() > 0) begin
      er = exp_q.pop_front();
      n_total++;
      $display("FAIL %s: expected output never observed, required x=%0d y=%0d rgb=%06h",
               name_q.pop_front(), er.x, er.y, er.rgb);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Video timing and test-pattern source that sits directly upstream of the SPI OSD overlay stage. It produces the pixel stream consumed by the overlay: 8-bit RGB, hsync, vsync and blank. It also emits the pixel coordinates and a frame-start strobe. All outputs are registered and mutually aligned, so the overlay can be driven without extra delay matching.

## Interface
Parameters:
- c_bits_x, 10, width of X counter and o_x
- c_bits_y, 10, width of Y counter and o_y
- c_h_visible / c_h_fporch / c_h_sync / c_h_bporch, 640/16/96/48, horizontal timing in pixels
- c_v_visible / c_v_fporch / c_v_sync / c_v_bporch, 480/10/2/33, vertical timing in lines
- c_hsync_pol, 0, hsync active level (0 = active low)
- c_vsync_pol, 0, vsync active level (0 = active low)
- c_bar_bits, 6, colour bar width is 2**c_bar_bits pixels
- c_solid_color, 24'h503020, RRGGBB colour for solid mode

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- clk_pixel_ena  in  1  pixel advance enable; all state holds when low
- i_mode  in  2  pattern select (0 bars, 1 grid, 2 gradient, 3 solid)
- o_r, o_g, o_b  out  8 each  pixel colour, 0 during blank
- o_hsync, o_vsync  out  1 each  sync at configured polarity
- o_blank  out  1  high outside the visible area
- o_x  out  c_bits_x  X of the current output pixel
- o_y  out  c_bits_y  Y of the current output pixel
- o_frame_start  out  1  high for the one output pixel at (0,0)

## Operation
- Derived totals: H_TOT = sum of the four horizontal parameters (800 by default); V_TOT = sum of the four vertical parameters (525 by default).
- X counter: counts 0..H_TOT-1 and advances on each enabled clock.
- Y counter: counts 0..V_TOT-1 and advances when X wraps from H_TOT-1 to 0.
- Frame wrap: Y wraps to 0 when X wraps and Y == V_TOT-1.
- Blank: o_blank = (x >= c_h_visible) or (y >= c_v_visible).
- Hsync: active when x is in [c_h_visible+c_h_fporch, c_h_visible+c_h_fporch+c_h_sync-1]; otherwise inactive.
- Vsync: active when y is in [c_v_visible+c_v_fporch, c_v_visible+c_v_fporch+c_v_sync-1]. Vsync depends on y only, for whole lines including horizontal blanking.
- Mode latch: i_mode is sampled into a mode register only on the enabled cycle where the counter is at (0,0). A mid-frame change of i_mode takes effect at the next frame.
- Frame counter: 8-bit, increments on the enabled cycle where the counter wraps (H_TOT-1, V_TOT-1) to (0,0); wraps 255 -> 0.
- Pattern, visible area only:
  - mode 0 (bars): index = x[c_bar_bits+2:c_bar_bits]. r = 8{index[2]}, g = 8{index[1]}, b = 8{index[0]}. Bar 0 is black, bar 7 is white, and the bars repeat beyond 8*2**c_bar_bits.
  - mode 1 (grid): white when x[3:0]==0, y[3:0]==0, x==c_h_visible-1 or y==c_v_visible-1; otherwise black.
  - mode 2 (gradient): r = x[7:0], g = y[7:0], b = frame counter.
  - mode 3 (solid): c_solid_color.
- Blank override: when blank is high, RGB is forced to 0 regardless of mode.
- Counter comparisons are unsigned at c_bits_x/c_bits_y width. Parameters must satisfy H_TOT <= 2**c_bits_x and V_TOT <= 2**c_bits_y; there is no run-time check.

## Timing
- Pipeline: one register stage. On an enabled edge, the outputs take the values computed from the current counter (x,y) and the latched mode, while the counter advances. Latency from counter to outputs is 1 enabled clock, identical for every output.
- Mode selection at frame start: the pixel at (0,0) uses the newly sampled i_mode.
- Reset values, applied at any edge with reset high (regardless of clk_pixel_ena):
  - counters = (0,0); mode = 0; frame counter = 0.
  - o_r = o_g = o_b = 0; o_blank = 1; o_hsync = !c_hsync_pol; o_vsync = !c_vsync_pol.
  - o_x = 0; o_y = 0; o_frame_start = 0.
- Reset mid-frame: outputs return to reset values at that edge. The first enabled edge after reset deasserts outputs pixel (0,0) with o_frame_start = 1, samples i_mode, and moves the counter to (1,0).
- With clk_pixel_ena low, all registers hold their values; outputs stay static.
- o_frame_start is high exactly once per V_TOT*H_TOT enabled clocks.

## Test plan
- Default parameters, clk_pixel_ena always 1, mode 0 → 800 clocks between hsync falling edges. Hsync low for 96 clocks, starting at o_x = 656. Vsync low for 1600 clocks (2 lines) starting at o_y = 490. o_frame_start period = 420000 clocks.
- Mode 0 → o_x = 0..63 gives RGB 000000; o_x = 64 gives 0000FF; o_x = 448 gives FFFFFF; o_x = 640..799 gives 0 with o_blank = 1.
- Mode 2 for 3 frames → at (5,7), RGB = 05,07,frame counter, and the frame counter reads 0, 1, 2 in successive frames. Force 256 frames → frame counter wraps to 0.
- Switch i_mode from 0 to 3 at o_y = 100 → the rest of that frame stays bars. Next (0,0) output = 503020 with o_frame_start = 1.
- clk_pixel_ena toggling 1,0,1,0 → outputs change only after enabled edges. Hsync period = 1600 clocks. o_x sequence has no gaps or repeats.
- Assert reset for 1 clock at (300,200) → next edge outputs reset values (blank = 1, syncs high, RGB = 0). First enabled edge after release → o_x = 0, o_y = 0, o_frame_start = 1.
